// File: rtl/compound_seq_producer.sv
// -----------------------------------------------------------------------------
// compound_seq_producer
//
// Produces a stream of compound {x, y} messages on a blocking master port
// using a notify/sync handshake. x is a running sequence number, y is the
// accumulator of the channel the message belongs to, and channels are visited
// round-robin. A burst of INIT_COUNT messages is sent, after which the block
// parks until restart is pulsed; the sequence and accumulators then continue
// where they left off.
//
// Parameters:
//   DATA_W     - width of x, y and in_step
//   NUM_CH     - number of channels (>= 1)
//   INIT_COUNT - messages per burst (>= 1, fits in 32 bits)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   in_step      in   accumulator increment, sampled in SEC_CALC
//   restart      in   starts a new burst, honoured only in SEC_HOLD
//   m_out_sync   in   consumer accepts the offered message
//   m_out_x      out  message sequence number
//   m_out_y      out  accumulator value of the current channel
//   m_out_ch     out  current channel index
//   m_out_notify out  message valid
//   m_out_parity out  XOR of {ch, x, y}; present only with the macro below
//   busy         out  high while a burst is in progress
//
// Build option:
//   COMPOUND_SEQ_PARITY_EN - when defined, adds the m_out_parity output.
// -----------------------------------------------------------------------------
module compound_seq_producer #(
  parameter  int DATA_W     = 32,
  parameter  int NUM_CH     = 2,
  parameter  int INIT_COUNT = 30,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_step,
  input  logic              restart,
  input  logic              m_out_sync,
  output logic [DATA_W-1:0] m_out_x,
  output logic [DATA_W-1:0] m_out_y,
  output logic [CH_W-1:0]   m_out_ch,
  output logic              m_out_notify,
`ifdef COMPOUND_SEQ_PARITY_EN
  output logic              m_out_parity,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    SEC_SEND,
    SEC_CALC,
    SEC_HOLD
  } section_t;

  section_t          r_section;
  section_t          w_section_nxt;
  logic [DATA_W-1:0] r_x;
  logic [CH_W-1:0]   r_ch;
  logic [DATA_W-1:0] r_acc [NUM_CH];
  logic [31:0]       r_remaining;
  logic              w_transfer;
  logic              w_last;

  assign w_transfer = m_out_notify & m_out_sync;
  assign w_last     = (r_remaining == 32'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_section <= SEC_SEND;
    end else begin
      r_section <= w_section_nxt;
    end
  end

  // NOTE: the next state is defaulted to the current state before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_section_nxt = r_section;
    unique case (r_section)
      SEC_SEND: if (w_transfer) w_section_nxt = SEC_CALC;
      SEC_CALC: w_section_nxt = w_last ? SEC_HOLD : SEC_SEND;
      SEC_HOLD: if (restart) w_section_nxt = SEC_SEND;
      default:  w_section_nxt = SEC_SEND;
    endcase
  end

  // NOTE: the accumulator array is architectural state (y must read 0 after
  // reset), so it is reset element by element rather than left uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= '0;
      r_ch        <= '0;
      r_remaining <= 32'(INIT_COUNT);
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      unique case (r_section)
        SEC_CALC: begin
          r_acc[r_ch] <= r_acc[r_ch] + in_step;
          r_x         <= r_x + 1'b1;
          r_ch        <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
          r_remaining <= r_remaining - 32'd1;
        end
        SEC_HOLD: begin
          if (restart) r_remaining <= 32'(INIT_COUNT);
        end
        default: ;
      endcase
    end
  end

  // Message fields only move in SEC_CALC, so they are stable while notify=1.
  assign m_out_x      = r_x;
  assign m_out_y      = r_acc[r_ch];
  assign m_out_ch     = r_ch;
  assign m_out_notify = (r_section == SEC_SEND);
  assign busy         = (r_section != SEC_HOLD);

`ifdef COMPOUND_SEQ_PARITY_EN
  assign m_out_parity = ^{m_out_ch, m_out_x, m_out_y};
`endif

endmodule

// File: tb/tb_compound_seq_producer.sv
// -----------------------------------------------------------------------------
// tb_compound_seq_producer
//
// Drives compound_seq_producer (DATA_W=4, NUM_CH=2, INIT_COUNT=3) with a
// directed opening sequence, a long randomized run and a mid-burst reset.
// A transfer-count based reference model predicts notify/busy and the message
// fields; literal expectations pin the model at known points.
// -----------------------------------------------------------------------------
module tb_compound_seq_producer;

  localparam int DW  = 4;
  localparam int NCH = 2;
  localparam int IC  = 3;
  localparam int CW  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_step = '0;
  logic          restart = 1'b0;
  logic          m_out_sync = 1'b0;
  logic [DW-1:0] m_out_x;
  logic [DW-1:0] m_out_y;
  logic [CW-1:0] m_out_ch;
  logic          m_out_notify;
  logic          busy;
`ifdef COMPOUND_SEQ_PARITY_EN
  logic          m_out_parity;
`endif

  compound_seq_producer #(
    .DATA_W    (DW),
    .NUM_CH    (NCH),
    .INIT_COUNT(IC)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_step     (in_step),
    .restart     (restart),
    .m_out_sync  (m_out_sync),
    .m_out_x     (m_out_x),
    .m_out_y     (m_out_y),
    .m_out_ch    (m_out_ch),
    .m_out_notify(m_out_notify),
`ifdef COMPOUND_SEQ_PARITY_EN
    .m_out_parity(m_out_parity),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_n counts accepted messages since reset; message k has
  // x = k mod 2^DW, ch = k mod NCH, and y is the running sum of the steps
  // applied to that channel. m_gap: 0 offering, 1 cycle after a transfer,
  // 2 parked after a full burst.
  // ---------------------------------------------------------------------------
  int m_n;
  int m_burst;
  int m_gap;
  int m_acc [NCH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n     <= 0;
      m_burst <= 0;
      m_gap   <= 0;
      for (int i = 0; i < NCH; i++) m_acc[i] <= 0;
    end else begin
      case (m_gap)
        0: if (m_out_sync) begin
          m_n     <= m_n + 1;
          m_burst <= m_burst + 1;
          m_gap   <= 1;
        end
        1: begin
          m_acc[(m_n - 1) % NCH] <= (m_acc[(m_n - 1) % NCH] + int'(in_step)) % (1 << DW);
          m_gap <= (m_burst == IC) ? 2 : 0;
        end
        default: if (restart) begin
          m_burst <= 0;
          m_gap   <= 0;
        end
      endcase
    end
  end

  // Compare process: handshake every cycle, fields whenever a message is offered.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("notify", 32'(m_out_notify), 32'(m_gap == 0));
      check("busy",   32'(busy),         32'(m_gap != 2));
      if (m_gap == 0) begin
        check("x",  32'(m_out_x),  32'(m_n % (1 << DW)));
        check("ch", 32'(m_out_ch), 32'(m_n % NCH));
        check("y",  32'(m_out_y),  32'(m_acc[m_n % NCH]));
`ifdef COMPOUND_SEQ_PARITY_EN
        check("parity", 32'(m_out_parity),
              32'(^{CW'(m_n % NCH), DW'(m_n % (1 << DW)), DW'(m_acc[m_n % NCH])}));
`endif
      end
    end
  end

  // Captures every accepted message as seen by the consumer.
  logic [31:0] cap_x [$];
  logic [31:0] cap_y [$];
  logic [31:0] cap_ch[$];

  always @(posedge clk) begin
    if (!rst && m_out_notify && m_out_sync) begin
      cap_x.push_back(32'(m_out_x));
      cap_y.push_back(32'(m_out_y));
      cap_ch.push_back(32'(m_out_ch));
    end
  end

  task automatic wait_gap(input int gap, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_gap == gap) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    // Reset state, checked while reset is still asserted.
    repeat (2) @(negedge clk);
    check("rst_notify", 32'(m_out_notify), 32'd1);
    check("rst_busy",   32'(busy),         32'd1);
    check("rst_x",      32'(m_out_x),      32'd0);
    check("rst_y",      32'(m_out_y),      32'd0);
`ifdef COMPOUND_SEQ_PARITY_EN
    check("rst_parity", 32'(m_out_parity), 32'd0);
`endif
    rst    = 1'b0;
    chk_en = 1'b1;

    // Idle with sync low: first message held.
    repeat (5) @(negedge clk);
    check("idle_notify", 32'(m_out_notify), 32'd1);
    check("idle_ch",     32'(m_out_ch),     32'd0);

    // Directed burst: message 1 backpressured for 3 offered cycles,
    // restart pulses while busy must be ignored.
    in_step    = DW'(5);
    m_out_sync = 1'b1;
    restart    = 1'b1;
    @(negedge clk);
    check("xfer0_notify_low", 32'(m_out_notify), 32'd0);
    m_out_sync = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_x_held", 32'(m_out_x), 32'd1);
    restart    = 1'b0;
    m_out_sync = 1'b1;
    wait_gap(2, 20, "reach_hold");
    m_out_sync = 1'b0;
    check("hold_busy",   32'(busy),         32'd0);
    check("hold_notify", 32'(m_out_notify), 32'd0);
    check("burst_len", 32'(cap_x.size()), 32'd3);
    if (cap_x.size() == 3) begin
      check("m0_x", cap_x[0], 32'd0); check("m0_ch", cap_ch[0], 32'd0); check("m0_y", cap_y[0], 32'd0);
      check("m1_x", cap_x[1], 32'd1); check("m1_ch", cap_ch[1], 32'd1); check("m1_y", cap_y[1], 32'd0);
      check("m2_x", cap_x[2], 32'd2); check("m2_ch", cap_ch[2], 32'd0); check("m2_y", cap_y[2], 32'd5);
    end
    repeat (2) @(negedge clk);
    check("still_hold", 32'(busy), 32'd0);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_notify", 32'(m_out_notify), 32'd1);
    check("restart_x",      32'(m_out_x),      32'd3);
    check("restart_ch",     32'(m_out_ch),     32'd1);
    check("restart_y",      32'(m_out_y),      32'd5);

    // Randomized run: long enough for x to wrap several times.
    repeat (1500) begin
      @(negedge clk);
      m_out_sync = ($urandom_range(0, 1) == 1);
      restart    = ($urandom_range(0, 9) < 3);
      in_step    = DW'($urandom_range(0, 15));
    end
    check("wrapped", 32'(m_n > 20), 32'd1);

    // Asynchronous reset in the cycle after a transfer.
    m_out_sync = 1'b1;
    restart    = 1'b1;
    wait_gap(1, 40, "reach_calc");
    #2 rst = 1'b1;
    #1;
    check("mid_rst_notify", 32'(m_out_notify), 32'd1);
    check("mid_rst_busy",   32'(busy),         32'd1);
    check("mid_rst_x",      32'(m_out_x),      32'd0);
    check("mid_rst_y",      32'(m_out_y),      32'd0);
    check("mid_rst_ch",     32'(m_out_ch),     32'd0);
    cap_x.delete(); cap_y.delete(); cap_ch.delete();
    restart = 1'b0;
    in_step = DW'(3);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_count", 32'(cap_x.size()), 32'd2);
    if (cap_x.size() >= 2) begin
      check("post_rst_m0_x", cap_x[0], 32'd0);
      check("post_rst_m1_x", cap_x[1], 32'd1);
      check("post_rst_m1_y", cap_y[1], 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
